ex_stage_sequencer: RTL and testbench
=====================================

Name: ex_stage_sequencer

Overview:
Multi-cycle control FSM for the 16-bit core. It sequences the shared datapath (IF, ID, EX, MEM, WB) one instruction at a time and drives the EX-stage controls Branch, ALUSrc and ALUOp. It waits on a memory ready handshake and traps on halt or illegal opcodes. It sits between instruction memory/IR and the EX block, taking opcode from ir[15:12] and the ALU Zero flag.

Parameters:
RET_W, 16, width of retired-instruction counter (saturating)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  4  ir[15:12], valid from DECODE onward (IR held stable by ir_write=0)
zero  in  1  ALU Zero flag from EX, sampled in EXEC
mem_ready  in  1  memory done; may be high in the same cycle as mem_req
mem_req  out  1  memory access request, held until mem_ready
mem_write  out  1  qualifies mem_req as a store
ir_write  out  1  load IR (fetch completing)
pc_write  out  1  PC update strobe
pc_src  out  2  00 PC+2, 01 branch target, 10 jump target
Branch  out  1  branch instruction in EXEC
ALUSrc  out  1  0 = readData2, 1 = sign-extended immediate
ALUOp  out  2  00 add, 01 sub (compare), 10 funct-decoded
reg_write  out  1  register file write strobe
mem_to_reg  out  1  write-back source is memory
halted  out  1  sticky, set by HALT
illegal  out  1  sticky, set by an undefined opcode
retired  out  RET_W  count of completed instructions

Behaviour:
- Reset (asynchronous, any state, including mid memory wait): state=FETCH, latched opcode=0, retired=0, halted=0, illegal=0, all strobes 0. The first mem_req rises on the first clock edge after reset is released.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP. State and opcode are registered. Outputs are decoded from state and the latched opcode. pc_write in EXEC for BEQ also depends on zero.
- FETCH: mem_req=1, mem_write=0. Stay in FETCH while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next state DECODE.
- DECODE: latch opcode, then go to EXEC. If the opcode is undefined, go to TRAP instead.
- Opcodes:
  - 0001 R-type: ALUOp=10, ALUSrc=0.
  - 0010 ADDI: ALUOp=00, ALUSrc=1.
  - 0011 LW and 0100 SW: ALUOp=00, ALUSrc=1.
  - 0101 BEQ: ALUOp=01, ALUSrc=0, Branch=1.
  - 0110 JMP.
  - 1111 HALT.
  - All other opcodes are illegal.
- EXEC:
  - R-type/ADDI: next state WB.
  - LW/SW: next state MEM.
  - BEQ: pc_write=zero, pc_src=01. Retire, then go to FETCH.
  - JMP: pc_write=1, pc_src=10. Retire, then go to FETCH.
  - HALT: set halted, retire, go to HALT.
  - ALUOp/ALUSrc/Branch are valid only in EXEC and are 0 elsewhere.
- MEM: mem_req=1, mem_write=(SW). Stay in MEM while mem_ready=0. On mem_ready: SW retires and goes to FETCH; LW goes to WB.
- WB: reg_write=1, mem_to_reg=(LW). Retire, then go to FETCH.
- Cycle counts with zero-wait memory:
  - R/ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/JMP: 3.
  - Each mem_ready=0 cycle adds one.
- HALT: absorbing state; only reset exits. All strobes 0, halted=1.
- TRAP: absorbing state; only reset exits. illegal=1. The trapping instruction does not retire.
- retired: increments exactly once per retiring transition and saturates at all-ones (no wrap).
- mem_ready while mem_req=0 is ignored.

Decomposition:
- Shared package:
  - State enum.
  - Opcode constants: OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT.
  - ALUOp constants: ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10.
  - pc_src constants.
- Sub-module: ex_ctrl_decode, combinational. Maps (state, opcode, zero) to the output strobes. The FSM module keeps the state and opcode registers and the retired counter.

Test Plan:
- Reset, then R-type (opcode 0001), mem_ready tied 1 -> ir_write at cycle 1, EXEC at cycle 3 with ALUOp=10/ALUSrc=0, reg_write at cycle 4, retired=1.
- LW with mem_ready low for 2 cycles in MEM -> mem_req held 3 cycles with mem_write=0, then WB with mem_to_reg=1 and reg_write=1. Total 7 cycles.
- BEQ with zero=1 then BEQ with zero=0 -> EXEC Branch=1, ALUOp=01. pc_write=1/pc_src=01 for the first, pc_write=0 for the second. Each takes 3 cycles; retired=2.
- Opcode 1001 -> TRAP after DECODE, illegal=1, retired unchanged, no further mem_req. Reset clears illegal.
- HALT (1111) -> halted=1, retired+1, outputs quiet for 20 cycles regardless of mem_ready.
- Assert reset during a MEM wait of SW -> immediate FETCH, mem_req=0 while reset is held, no mem_write pulse, retired=0.

Source files
------------

// File: rtl/ex_stage_sequencer_pkg.sv
// Shared types and encodings for the multi-cycle EX-stage sequencer.
// Opcodes come from ir[15:12]; ALUOp and pc_src encodings are driven toward the EX block.
package ex_stage_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  localparam logic [3:0] OP_R    = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_PLUS2  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_sequencer_if.sv
// Control bundle between the sequencer (master) and the IR/memory/EX datapath (slave).
interface ex_stage_sequencer_if #(parameter int RET_W = 16);
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             Branch;
  logic             ALUSrc;
  logic [1:0]       ALUOp;
  logic             reg_write;
  logic             mem_to_reg;
  logic             halted;
  logic             illegal;
  logic [RET_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, ir_write, pc_write, pc_src, Branch, ALUSrc, ALUOp,
           reg_write, mem_to_reg, halted, illegal, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, ir_write, pc_write, pc_src, Branch, ALUSrc, ALUOp,
           reg_write, mem_to_reg, halted, illegal, retired
  );
endinterface

// File: rtl/ex_ctrl_decode.sv
// Combinational strobe decode from (state, latched opcode, zero, mem_ready).
// Everything is forced quiet while active_i is low (reset and the cycle right after it).
module ex_ctrl_decode
  import ex_stage_sequencer_pkg::*;
(
  input  logic       active_i,
  input  state_e     state_i,
  input  logic [3:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       branch_o,
  output logic       alu_src_o,
  output logic [1:0] alu_op_o,
  output logic       reg_write_o,
  output logic       mem_to_reg_o,
  output logic       halted_o,
  output logic       illegal_o
);

  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PC_PLUS2;
    branch_o     = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = ALU_ADD;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    halted_o     = 1'b0;
    illegal_o    = 1'b0;
    if (active_i) begin
      case (state_i)
        S_FETCH: begin
          mem_req_o  = 1'b1;
          ir_write_o = mem_ready_i;
          pc_write_o = mem_ready_i;
        end
        S_EXEC: begin
          case (op_i)
            OP_R:                begin alu_op_o = ALU_FUNCT; end
            OP_ADDI, OP_LW, OP_SW: begin alu_op_o = ALU_ADD; alu_src_o = 1'b1; end
            OP_BEQ: begin
              alu_op_o   = ALU_SUB;
              branch_o   = 1'b1;
              pc_src_o   = PC_BRANCH;
              pc_write_o = zero_i;
            end
            OP_JMP: begin
              pc_write_o = 1'b1;
              pc_src_o   = PC_JUMP;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req_o   = 1'b1;
          mem_write_o = (op_i == OP_SW);
        end
        S_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = (op_i == OP_LW);
        end
        S_HALT:  halted_o  = 1'b1;
        S_TRAP:  illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: state, latched opcode and retired counter.
// HALT and TRAP are absorbing; only reset leaves them.
module ex_stage_sequencer
  import ex_stage_sequencer_pkg::*;
#(
  parameter int RET_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  ex_stage_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic             run_q;
  logic             retire;

  // run_q holds the first fetch back until one clean edge has passed after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      retired_q <= '0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      retired_q <= retired_d;
      run_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    retire   = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          opcode_d = bus.opcode;
          state_d  = op_legal(bus.opcode) ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          case (opcode_q)
            OP_R, OP_ADDI:  state_d = S_WB;
            OP_LW, OP_SW:   state_d = S_MEM;
            OP_BEQ, OP_JMP: begin state_d = S_FETCH; retire = 1'b1; end
            OP_HALT:        begin state_d = S_HALT;  retire = 1'b1; end
            default:        state_d = S_TRAP;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (opcode_q == OP_SW) begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB:    begin state_d = S_FETCH; retire = 1'b1; end
        S_HALT:  state_d = S_HALT;
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_FETCH;
      endcase
    end
    retired_d = (retire && (retired_q != '1)) ? retired_q + RET_W'(1) : retired_q;
  end

  assign bus.retired = retired_q;

  ex_ctrl_decode u_decode (
    .active_i     (run_q),
    .state_i      (state_q),
    .op_i         (opcode_q),
    .zero_i       (bus.zero),
    .mem_ready_i  (bus.mem_ready),
    .mem_req_o    (bus.mem_req),
    .mem_write_o  (bus.mem_write),
    .ir_write_o   (bus.ir_write),
    .pc_write_o   (bus.pc_write),
    .pc_src_o     (bus.pc_src),
    .branch_o     (bus.Branch),
    .alu_src_o    (bus.ALUSrc),
    .alu_op_o     (bus.ALUOp),
    .reg_write_o  (bus.reg_write),
    .mem_to_reg_o (bus.mem_to_reg),
    .halted_o     (bus.halted),
    .illegal_o    (bus.illegal)
  );

endmodule

// File: tb/tb_ex_stage_sequencer.sv
// Directed bench for ex_stage_sequencer: per-cycle strobe vectors against hand-derived tables.
module tb_ex_stage_sequencer;

  localparam int RW = 4;

  // {mem_req, mem_write, ir_write, pc_write, pc_src, Branch, ALUSrc, ALUOp, reg_write, mem_to_reg, halted, illegal}
  localparam logic [13:0] IDLE       = 14'd0;
  localparam logic [13:0] FETCH_GO   = 14'b1_0_1_1_00_0_0_00_0_0_0_0;
  localparam logic [13:0] FETCH_WAIT = 14'b1_0_0_0_00_0_0_00_0_0_0_0;
  localparam logic [13:0] EX_R       = 14'b0_0_0_0_00_0_0_10_0_0_0_0;
  localparam logic [13:0] EX_I       = 14'b0_0_0_0_00_0_1_00_0_0_0_0;
  localparam logic [13:0] EX_BT      = 14'b0_0_0_1_01_1_0_01_0_0_0_0;
  localparam logic [13:0] EX_BN      = 14'b0_0_0_0_01_1_0_01_0_0_0_0;
  localparam logic [13:0] EX_J       = 14'b0_0_0_1_10_0_0_00_0_0_0_0;
  localparam logic [13:0] MEM_RD     = 14'b1_0_0_0_00_0_0_00_0_0_0_0;
  localparam logic [13:0] MEM_WR     = 14'b1_1_0_0_00_0_0_00_0_0_0_0;
  localparam logic [13:0] WB_R       = 14'b0_0_0_0_00_0_0_00_1_0_0_0;
  localparam logic [13:0] WB_LW      = 14'b0_0_0_0_00_0_0_00_1_1_0_0;
  localparam logic [13:0] HLT        = 14'b0_0_0_0_00_0_0_00_0_0_1_0;
  localparam logic [13:0] TRP        = 14'b0_0_0_0_00_0_0_00_0_0_0_1;

  logic clock;
  logic reset;
  int   tests;
  int   failed;

  ex_stage_sequencer_if #(.RET_W(RW)) bus ();

  ex_stage_sequencer #(.RET_W(RW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [13:0] obs();
    return {bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_src,
            bus.Branch, bus.ALUSrc, bus.ALUOp, bus.reg_write, bus.mem_to_reg,
            bus.halted, bus.illegal};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench at posedge+1 of cycle 1 (first FETCH cycle).
  task automatic do_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 4'h0;
    bus.zero      = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 4'h1;
    bus.zero      = 1'b0;
    cyc();
    #1;
    tests++;
    if (obs() !== IDLE) begin failed++; $display("FAIL reset_strobes got=%b exp=%b", obs(), IDLE); end
    tests++;
    if (bus.retired !== 4'd0) begin failed++; $display("FAIL reset_retired got=%0d exp=0", bus.retired); end
    cyc();
    reset = 1'b0;
    #1;
    tests++;
    if (bus.mem_req !== 1'b0) begin failed++; $display("FAIL reset_release_mem_req got=%b exp=0", bus.mem_req); end
    cyc();
  endtask

  task automatic test_rtype();
    logic [13:0] e[5];
    logic        mr[5];
    e  = '{FETCH_GO, IDLE, EX_R, WB_R, FETCH_WAIT};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.opcode = 4'h1;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = mr[i];
      #1;
      tests++;
      if (obs() !== e[i]) begin failed++; $display("FAIL rtype c%0d got=%b exp=%b", i + 1, obs(), e[i]); end
      if (i < 4) cyc();
    end
    tests++;
    if (bus.retired !== 4'd1) begin failed++; $display("FAIL rtype_retired got=%0d exp=1", bus.retired); end
  endtask

  task automatic test_lw_wait();
    logic [13:0] e[8];
    logic        mr[8];
    e  = '{FETCH_GO, IDLE, EX_I, MEM_RD, MEM_RD, MEM_RD, WB_LW, FETCH_WAIT};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.opcode = 4'h3;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = mr[i];
      #1;
      tests++;
      if (obs() !== e[i]) begin failed++; $display("FAIL lw c%0d got=%b exp=%b", i + 1, obs(), e[i]); end
      if (i < 7) cyc();
    end
    tests++;
    if (bus.retired !== 4'd2) begin failed++; $display("FAIL lw_retired got=%0d exp=2", bus.retired); end
  endtask

  task automatic test_beq();
    logic [13:0] e[7];
    logic        zr[7];
    e  = '{FETCH_GO, IDLE, EX_BT, FETCH_GO, IDLE, EX_BN, FETCH_WAIT};
    zr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bus.opcode = 4'h5;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = (i != 6);
      bus.zero      = zr[i];
      #1;
      tests++;
      if (obs() !== e[i]) begin failed++; $display("FAIL beq c%0d got=%b exp=%b", i + 1, obs(), e[i]); end
      if (i < 6) cyc();
    end
    tests++;
    if (bus.retired !== 4'd4) begin failed++; $display("FAIL beq_retired got=%0d exp=4", bus.retired); end
    bus.zero = 1'b0;
  endtask

  // JMP, SW and ADDI issued back to back with zero-wait memory.
  task automatic test_back_to_back();
    logic [13:0] e[12];
    logic [3:0]  op[12];
    e  = '{FETCH_GO, IDLE, EX_J, FETCH_GO, IDLE, EX_I, MEM_WR, FETCH_GO, IDLE, EX_I, WB_R, FETCH_WAIT};
    op = '{4'h6, 4'h6, 4'h6, 4'h4, 4'h4, 4'h4, 4'h4, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
    for (int i = 0; i < 12; i++) begin
      bus.opcode    = op[i];
      bus.mem_ready = (i != 11);
      #1;
      tests++;
      if (obs() !== e[i]) begin failed++; $display("FAIL b2b c%0d got=%b exp=%b", i + 1, obs(), e[i]); end
      if (i < 11) cyc();
    end
    tests++;
    if (bus.retired !== 4'd7) begin failed++; $display("FAIL b2b_retired got=%0d exp=7", bus.retired); end
  endtask

  task automatic test_halt();
    logic [13:0] e[3];
    e = '{FETCH_GO, IDLE, IDLE};
    bus.opcode = 4'hF;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'b1;
      #1;
      tests++;
      if (obs() !== e[i]) begin failed++; $display("FAIL halt c%0d got=%b exp=%b", i + 1, obs(), e[i]); end
      cyc();
    end
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      #1;
      tests++;
      if (obs() !== HLT) begin failed++; $display("FAIL halt_quiet c%0d got=%b exp=%b", i + 4, obs(), HLT); end
      cyc();
    end
    tests++;
    if (bus.retired !== 4'd8) begin failed++; $display("FAIL halt_retired got=%0d exp=8", bus.retired); end
    do_reset();
    tests++;
    if ({bus.halted, bus.retired} !== {1'b0, 4'd0}) begin
      failed++; $display("FAIL halt_reset_clear got=%b/%0d exp=0/0", bus.halted, bus.retired);
    end
  endtask

  task automatic test_trap();
    bus.opcode = 4'h9;
    bus.mem_ready = 1'b1;
    #1;
    tests++;
    if (obs() !== FETCH_GO) begin failed++; $display("FAIL trap_fetch got=%b exp=%b", obs(), FETCH_GO); end
    cyc();
    tests++;
    if (obs() !== IDLE) begin failed++; $display("FAIL trap_decode got=%b exp=%b", obs(), IDLE); end
    cyc();
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = i[0];
      #1;
      tests++;
      if (obs() !== TRP) begin failed++; $display("FAIL trap_stuck c%0d got=%b exp=%b", i + 3, obs(), TRP); end
      cyc();
    end
    tests++;
    if (bus.retired !== 4'd0) begin failed++; $display("FAIL trap_retired got=%0d exp=0", bus.retired); end
    reset = 1'b1;
    #1;
    tests++;
    if (bus.illegal !== 1'b0) begin failed++; $display("FAIL trap_reset_clear got=%b exp=0", bus.illegal); end
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  // JMP retires once, then reset lands in the middle of an SW memory wait.
  task automatic test_reset_mid_mem();
    logic [13:0] e[8];
    logic [3:0]  op[8];
    logic        mr[8];
    e  = '{FETCH_GO, IDLE, EX_J, FETCH_GO, IDLE, EX_I, MEM_WR, MEM_WR};
    op = '{4'h6, 4'h6, 4'h6, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      bus.opcode    = op[i];
      bus.mem_ready = mr[i];
      #1;
      tests++;
      if (obs() !== e[i]) begin failed++; $display("FAIL midmem c%0d got=%b exp=%b", i + 1, obs(), e[i]); end
      if (i < 7) cyc();
    end
    tests++;
    if (bus.retired !== 4'd1) begin failed++; $display("FAIL midmem_pre_retired got=%0d exp=1", bus.retired); end
    reset = 1'b1;
    #1;
    tests++;
    if (obs() !== IDLE) begin failed++; $display("FAIL midmem_async got=%b exp=%b", obs(), IDLE); end
    tests++;
    if (bus.retired !== 4'd0) begin failed++; $display("FAIL midmem_retired got=%0d exp=0", bus.retired); end
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'b1;
      cyc();
      tests++;
      if ({bus.mem_req, bus.mem_write} !== 2'b00) begin
        failed++; $display("FAIL midmem_held c%0d got=%b exp=00", i, {bus.mem_req, bus.mem_write});
      end
    end
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    cyc();
    #1;
    tests++;
    if (obs() !== FETCH_WAIT) begin failed++; $display("FAIL midmem_refetch got=%b exp=%b", obs(), FETCH_WAIT); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.opcode    = 4'h6;
    bus.mem_ready = 1'b1;
    repeat (45) cyc();
    tests++;
    if (bus.retired !== 4'd15) begin failed++; $display("FAIL sat_reach got=%0d exp=15", bus.retired); end
    repeat (6) cyc();
    tests++;
    if (bus.retired !== 4'd15) begin failed++; $display("FAIL sat_hold got=%0d exp=15", bus.retired); end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_back_to_back();
    test_halt();
    test_trap();
    test_reset_mid_mem();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
